// File: rtl/io_write_arbiter.sv
// io_write_arbiter: shares the single mcu_io write port between the CPU
// channel and an auxiliary master. Each channel owns a one-entry pending
// buffer behind a valid/ready handshake. Pending writes are issued one per
// cycle, and the grant alternates round-robin when both channels wait.
module io_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // CPU channel
    input  logic              cpu_wr_valid,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    output logic              cpu_wr_done,
    // AUX channel
    input  logic              aux_wr_valid,
    input  logic [ADDR_W-1:0] aux_wr_addr,
    input  logic [DATA_W-1:0] aux_wr_data,
    output logic              aux_wr_ready,
    output logic              aux_wr_done,
    // mcu_io write port
    output logic              output_write_enable,
    output logic [ADDR_W-1:0] output_data_address,
    output logic [DATA_W-1:0] output_data_in
);

    // Grant owner encoding for last_grant.
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_AUX = 1'b1;

    logic              cpu_pend_q, cpu_pend_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic              aux_pend_q, aux_pend_d;
    logic [ADDR_W-1:0] aux_addr_q, aux_addr_d;
    logic [DATA_W-1:0] aux_data_q, aux_data_d;
    logic              last_grant_q, last_grant_d;
    logic              wen_q, wen_d;
    logic              cpu_done_q, cpu_done_d;
    logic              aux_done_q, aux_done_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              cpu_accept, aux_accept;
    logic              gnt_cpu, gnt_aux;

    // Ready depends only on the buffer state and reset, never on valid.
    assign cpu_wr_ready = ~cpu_pend_q & ~reset;
    assign aux_wr_ready = ~aux_pend_q & ~reset;

    assign cpu_accept = cpu_wr_valid & cpu_wr_ready;
    assign aux_accept = aux_wr_valid & aux_wr_ready;

    // Round-robin grant: a lone pending channel wins; under contention the
    // channel that did not win last time wins. Acceptance requires an empty
    // buffer and a grant requires a full one, so the two never coincide.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_aux = 1'b0;
        if (cpu_pend_q && aux_pend_q) begin
            gnt_cpu = (last_grant_q == GNT_AUX);
            gnt_aux = (last_grant_q == GNT_CPU);
        end else begin
            gnt_cpu = cpu_pend_q;
            gnt_aux = aux_pend_q;
        end
    end

    // Next state for pending buffers, output port and grant history.
    always_comb begin
        cpu_pend_d   = cpu_pend_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_data_d   = cpu_data_q;
        aux_pend_d   = aux_pend_q;
        aux_addr_d   = aux_addr_q;
        aux_data_d   = aux_data_q;
        last_grant_d = last_grant_q;
        wen_d        = gnt_cpu | gnt_aux;
        cpu_done_d   = gnt_cpu;
        aux_done_d   = gnt_aux;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;

        if (gnt_cpu) begin
            out_addr_d   = cpu_addr_q;
            out_data_d   = cpu_data_q;
            cpu_pend_d   = 1'b0;
            last_grant_d = GNT_CPU;
        end else if (gnt_aux) begin
            out_addr_d   = aux_addr_q;
            out_data_d   = aux_data_q;
            aux_pend_d   = 1'b0;
            last_grant_d = GNT_AUX;
        end

        if (cpu_accept) begin
            cpu_pend_d = 1'b1;
            cpu_addr_d = cpu_wr_addr;
            cpu_data_d = cpu_wr_data;
        end
        if (aux_accept) begin
            aux_pend_d = 1'b1;
            aux_addr_d = aux_wr_addr;
            aux_data_d = aux_wr_data;
        end
    end

    // Control and output-port registers; reset discards any buffered write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_pend_q   <= 1'b0;
            aux_pend_q   <= 1'b0;
            last_grant_q <= GNT_AUX;
            wen_q        <= 1'b0;
            cpu_done_q   <= 1'b0;
            aux_done_q   <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
        end else begin
            cpu_pend_q   <= cpu_pend_d;
            aux_pend_q   <= aux_pend_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            cpu_done_q   <= cpu_done_d;
            aux_done_q   <= aux_done_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
        end
    end

    // Buffer payloads are only meaningful while pend is set, so no reset.
    always_ff @(posedge clk) begin
        cpu_addr_q <= cpu_addr_d;
        cpu_data_q <= cpu_data_d;
        aux_addr_q <= aux_addr_d;
        aux_data_q <= aux_data_d;
    end

    assign output_write_enable = wen_q;
    assign output_data_address = out_addr_q;
    assign output_data_in      = out_data_q;
    assign cpu_wr_done         = cpu_done_q;
    assign aux_wr_done         = aux_done_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Testbench for io_write_arbiter: directed scenarios followed by random
// traffic, checked against a per-edge behavioural model plus per-channel
// write queues that confirm every accepted write is issued exactly once.
module tb_io_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_wr_valid, aux_wr_valid;
    logic [7:0] cpu_wr_addr, cpu_wr_data, aux_wr_addr, aux_wr_data;
    logic       cpu_wr_ready, aux_wr_ready, cpu_wr_done, aux_wr_done;
    logic       output_write_enable;
    logic [7:0] output_data_address, output_data_in;

    io_write_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_wr_valid        (cpu_wr_valid),
        .cpu_wr_addr         (cpu_wr_addr),
        .cpu_wr_data         (cpu_wr_data),
        .cpu_wr_ready        (cpu_wr_ready),
        .cpu_wr_done         (cpu_wr_done),
        .aux_wr_valid        (aux_wr_valid),
        .aux_wr_addr         (aux_wr_addr),
        .aux_wr_data         (aux_wr_data),
        .aux_wr_ready        (aux_wr_ready),
        .aux_wr_done         (aux_wr_done),
        .output_write_enable (output_write_enable),
        .output_data_address (output_data_address),
        .output_data_in      (output_data_in)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (index 0 = CPU, 1 = AUX).
    bit        m_pend [2];
    bit [7:0]  m_addr [2];
    bit [7:0]  m_data [2];
    int        m_last;
    bit        e_wen, e_cdone, e_adone;
    bit [7:0]  e_addr, e_data;
    bit        acc_c, acc_a;
    bit [15:0] sbq_c[$];
    bit [15:0] sbq_a[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the specification's rules for one rising edge using the
    // inputs the bench is driving.
    task automatic model_edge();
        int g;
        acc_c = 1'b0;
        acc_a = 1'b0;
        if (reset) begin
            m_pend[0] = 1'b0; m_pend[1] = 1'b0;
            m_last = 1;
            e_wen = 1'b0; e_cdone = 1'b0; e_adone = 1'b0;
            e_addr = 8'h00; e_data = 8'h00;
            sbq_c.delete();
            sbq_a.delete();
        end else begin
            acc_c = cpu_wr_valid && !m_pend[0];
            acc_a = aux_wr_valid && !m_pend[1];
            if (m_pend[0] && m_pend[1]) g = (m_last == 1) ? 0 : 1;
            else if (m_pend[0])         g = 0;
            else if (m_pend[1])         g = 1;
            else                        g = -1;
            e_wen   = (g >= 0);
            e_cdone = (g == 0);
            e_adone = (g == 1);
            if (g >= 0) begin
                e_addr    = m_addr[g];
                e_data    = m_data[g];
                m_pend[g] = 1'b0;
                m_last    = g;
            end
            if (acc_c) begin
                m_pend[0] = 1'b1; m_addr[0] = cpu_wr_addr; m_data[0] = cpu_wr_data;
                sbq_c.push_back({cpu_wr_addr, cpu_wr_data});
            end
            if (acc_a) begin
                m_pend[1] = 1'b1; m_addr[1] = aux_wr_addr; m_data[1] = aux_wr_data;
                sbq_a.push_back({aux_wr_addr, aux_wr_data});
            end
        end
    endtask

    // One clock: drive at the falling edge, check ready, step the model at
    // the rising edge, then check registered outputs at the next falling edge.
    task automatic cycle(input bit rst,
                         input bit cv, input bit [7:0] ca, input bit [7:0] cd,
                         input bit av, input bit [7:0] aa, input bit [7:0] ad);
        bit [15:0] w;
        reset = rst;
        cpu_wr_valid = cv; cpu_wr_addr = ca; cpu_wr_data = cd;
        aux_wr_valid = av; aux_wr_addr = aa; aux_wr_data = ad;
        #1;
        check_eq("cpu_ready", cpu_wr_ready, !m_pend[0] && !rst);
        check_eq("aux_ready", aux_wr_ready, !m_pend[1] && !rst);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("wen",      output_write_enable, e_wen);
        check_eq("cpu_done", cpu_wr_done, e_cdone);
        check_eq("aux_done", aux_wr_done, e_adone);
        check_eq("addr",     output_data_address, e_addr);
        check_eq("data",     output_data_in, e_data);
        check_eq("done_excl", cpu_wr_done & aux_wr_done, 0);
        if (cpu_wr_done === 1'b1) begin
            if (sbq_c.size() == 0) check_eq("cpu_sb_extra", 1, 0);
            else begin
                w = sbq_c.pop_front();
                check_eq("cpu_sb_write", {output_data_address, output_data_in}, w);
            end
        end
        if (aux_wr_done === 1'b1) begin
            if (sbq_a.size() == 0) check_eq("aux_sb_extra", 1, 0);
            else begin
                w = sbq_a.pop_front();
                check_eq("aux_sb_write", {output_data_address, output_data_in}, w);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    endtask

    initial begin
        bit [7:0] cnt_c, cnt_a;
        int       sent_c, sent_a;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_last = 1;
        reset = 1'b1;
        cpu_wr_valid = 1'b0; cpu_wr_addr = 8'h00; cpu_wr_data = 8'h00;
        aux_wr_valid = 1'b0; aux_wr_addr = 8'h00; aux_wr_data = 8'h00;
        @(negedge clk);

        // Reset then idle.
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(5);

        // Single CPU write.
        cycle(0, 1, 8'h03, 8'hA5, 0, 8'h00, 8'h00);
        check_eq("single_ready_low", cpu_wr_ready, 0);
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        check_eq("single_wen",  output_write_enable, 1);
        check_eq("single_addr", output_data_address, 8'h03);
        check_eq("single_data", output_data_in, 8'hA5);
        idle(2);

        // Simultaneous acceptance after reset: CPU first, then AUX.
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        cycle(0, 1, 8'h01, 8'h11, 1, 8'h02, 8'h22);
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        check_eq("contest_first_cpu", {cpu_wr_done, output_data_in}, {1'b1, 8'h11});
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        check_eq("contest_second_aux", {aux_wr_done, output_data_in}, {1'b1, 8'h22});
        idle(1);

        // Both channels streaming 8 writes each with incrementing data.
        cnt_c = 8'h10; cnt_a = 8'h80; sent_c = 0; sent_a = 0;
        for (int i = 0; i < 40 && (sent_c < 8 || sent_a < 8); i++) begin
            cycle(0, sent_c < 8, 8'h20, cnt_c, sent_a < 8, 8'h30, cnt_a);
            if (acc_c) begin cnt_c++; sent_c++; end
            if (acc_a) begin cnt_a++; sent_a++; end
        end
        idle(3);
        check_eq("stream_cpu_drained", sbq_c.size(), 0);
        check_eq("stream_aux_drained", sbq_a.size(), 0);

        // CPU bus changes while its buffer is full are ignored.
        cycle(0, 1, 8'h06, 8'h66, 1, 8'h04, 8'h44);
        cycle(0, 1, 8'hFF, 8'hEE, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'hFE, 8'hED, 0, 8'h00, 8'h00);
        idle(2);

        // Reset right after acceptance discards the write.
        cycle(0, 1, 8'h05, 8'h55, 0, 8'h00, 8'h00);
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(4);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 1), 8'($urandom), 8'($urandom));
        end
        idle(3);
        check_eq("final_cpu_drained", sbq_c.size(), 0);
        check_eq("final_aux_drained", sbq_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
